// File: rtl/sequence_generator.sv
// Replays a loadable digit pattern repeat_cnt times with gap idle cycles between repetitions.
// Slot 0 appears one cycle after start is sampled; there is no backpressure, so start/load are ignored while busy.
module sequence_generator #(
    parameter int MAX_LEN = 8,
    parameter int DIGIT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [2:0]         load_addr,
    input  logic [DIGIT_W-1:0] load_data,
    input  logic [3:0]         seq_len,
    input  logic [3:0]         repeat_cnt,
    input  logic [3:0]         gap,
    input  logic               start,
    output logic [DIGIT_W-1:0] number,
    output logic               number_valid,
    output logic               busy,
    output logic               done
);

    localparam int                 AW       = $clog2(MAX_LEN);
    localparam logic [DIGIT_W-1:0] IDLE_SYM = '1;
    localparam logic [3:0]         MAX_L    = 4'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t             state;
    logic [DIGIT_W-1:0] mem [MAX_LEN];
    logic [3:0]         len_q;
    logic [3:0]         rep_left;
    logic [3:0]         gap_q;
    logic [3:0]         gap_cnt;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      idx_inc;
    logic               last_slot;
    logic [DIGIT_W-1:0] slot0;

    function automatic logic [DIGIT_W-1:0] rst_digit(input int i);
        case (i)
            0:       return DIGIT_W'(1);
            1:       return DIGIT_W'(0);
            2:       return DIGIT_W'(9);
            3:       return DIGIT_W'(4);
            default: return IDLE_SYM;
        endcase
    endfunction

    assign idx_inc   = idx + AW'(1);
    assign last_slot = (4'(idx) + 4'd1) >= len_q;
    // A load coinciding with start must be visible in the very first digit.
    assign slot0     = (load && load_addr == 3'd0) ? load_data : mem[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            number       <= IDLE_SYM;
            number_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            len_q        <= '0;
            rep_left     <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            idx          <= '0;
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= rst_digit(i);
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) mem[load_addr] <= load_data;
                    if (start && seq_len != 4'd0) begin
                        len_q        <= (seq_len > MAX_L) ? MAX_L : seq_len;
                        rep_left     <= (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
                        gap_q        <= gap;
                        idx          <= '0;
                        number       <= slot0;
                        number_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (!last_slot) begin
                        idx    <= idx_inc;
                        number <= mem[idx_inc];
                    end else if (rep_left > 4'd1) begin
                        rep_left <= rep_left - 4'd1;
                        idx      <= '0;
                        if (gap_q != 4'd0) begin
                            gap_cnt      <= gap_q;
                            number       <= IDLE_SYM;
                            number_valid <= 1'b0;
                            state        <= GAP;
                        end else begin
                            number <= mem[0];
                        end
                    end else begin
                        number       <= IDLE_SYM;
                        number_valid <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd1) begin
                        number       <= mem[0];
                        number_valid <= 1'b1;
                        state        <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
